// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - single-port SRAM slave with req/ready handshake, byte lanes, optional RAM_PARITY_EN
module sram_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4096,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    ready_o,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    wack_o,
    output logic                    err_o
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int OFS    = $clog2(NBYTES);
    localparam int IDXW   = $clog2(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IDXW-1:0] idx;
    logic            oor;
    logic            accept;
    logic            rd_par_err;

    // Word index from the byte address; any bit above the array span means out of range (no aliasing).
    assign idx    = addr_i[OFS+IDXW-1:OFS];
    assign oor    = (addr_i >> (OFS + IDXW)) != '0;
    assign accept = req_i && ready_o;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and ready: one accept in IDLE, then one response cycle.
    always_comb begin
        state_nxt = state;
        ready_o   = 1'b0;
        case (state)
            S_IDLE: begin
                ready_o = 1'b1;
                if (req_i) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Byte-lane write into the array; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst && accept && we_i && !oor) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (be_i[b]) begin
                    mem[idx][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

`ifdef RAM_PARITY_EN
    logic [NBYTES-1:0] par [DEPTH];

    // Even parity per lane, stored only for the lanes being written.
    always_ff @(posedge clk) begin
        if (rst && accept && we_i && !oor) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (be_i[b]) begin
                    par[idx][b] <= ^wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Any lane whose recomputed parity disagrees with the stored bit flags the read.
    always_comb begin
        rd_par_err = 1'b0;
        for (int b = 0; b < NBYTES; b++) begin
            if ((^mem[idx][b*8 +: 8]) != par[idx][b]) begin
                rd_par_err = 1'b1;
            end
        end
    end
`else
    assign rd_par_err = 1'b0;
`endif

    // Response registers: one-cycle pulses in RESP; rdata holds until the next read response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rvalid_o <= 1'b0;
            wack_o   <= 1'b0;
            err_o    <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= 1'b0;
            wack_o   <= 1'b0;
            err_o    <= 1'b0;
            if (accept) begin
                if (we_i) begin
                    wack_o <= 1'b1;
                    err_o  <= oor;
                end else begin
                    rvalid_o <= 1'b1;
                    err_o    <= oor || rd_par_err;
                    rdata_o  <= oor ? '0 : mem[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - directed self-checking bench for sram_ctrl
module tb_sram_ctrl;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        wack;
    logic        err;

    int errors = 0;
    int checks = 0;

    sram_ctrl #(
        .DATA_WIDTH (32),
        .DEPTH      (4096),
        .ADDR_WIDTH (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req),
        .we_i     (we),
        .addr_i   (addr),
        .be_i     (be),
        .wdata_i  (wdata),
        .ready_o  (ready),
        .rvalid_o (rvalid),
        .rdata_o  (rdata),
        .wack_o   (wack),
        .err_o    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the RESP cycle.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        int n = 0;
        while (!ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready_timeout", {63'd0, ready}, 64'd1);
        req   = 1'b1;
        we    = w;
        addr  = a;
        be    = b;
        wdata = d;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;

        // Reset
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("rst_ready",  {63'd0, ready},  64'd1);
        check("rst_rvalid", {63'd0, rvalid}, 64'd0);
        check("rst_wack",   {63'd0, wack},   64'd0);
        check("rst_err",    {63'd0, err},    64'd0);
        check("rst_rdata",  {32'd0, rdata},  64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Full write then read
        xfer(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        check("w_wack",   {63'd0, wack},   64'd1);
        check("w_err",    {63'd0, err},    64'd0);
        check("w_rvalid", {63'd0, rvalid}, 64'd0);
        check("w_ready",  {63'd0, ready},  64'd0);
        @(negedge clk);
        check("w_wack_drop", {63'd0, wack}, 64'd0);
        xfer(1'b0, 32'h10, 4'h0, 32'h0);
        check("r_rvalid", {63'd0, rvalid}, 64'd1);
        check("r_rdata",  {32'd0, rdata},  64'h0DEADBEEF);
        check("r_err",    {63'd0, err},    64'd0);
        check("r_wack",   {63'd0, wack},   64'd0);
        @(negedge clk);
        check("r_rvalid_drop", {63'd0, rvalid}, 64'd0);
        check("r_rdata_hold",  {32'd0, rdata},  64'h0DEADBEEF);

        // Byte lanes
        xfer(1'b1, 32'h10, 4'b0101, 32'h11223344);
        @(negedge clk);
        xfer(1'b0, 32'h10, 4'h0, 32'h0);
        check("lane_rdata", {32'd0, rdata}, 64'h0DE22BE44);
        @(negedge clk);

        // Out of range: 0x4000 would alias index 0 if wrapped
        xfer(1'b1, 32'h0, 4'hF, 32'h01234567);
        @(negedge clk);
        xfer(1'b1, 32'h4000, 4'hF, 32'hFFFFFFFF);
        check("oor_w_wack", {63'd0, wack}, 64'd1);
        check("oor_w_err",  {63'd0, err},  64'd1);
        @(negedge clk);
        check("oor_err_drop", {63'd0, err}, 64'd0);
        xfer(1'b0, 32'h0, 4'h0, 32'h0);
        check("oor_mem_kept", {32'd0, rdata}, 64'h001234567);
        @(negedge clk);
        xfer(1'b0, 32'h4000, 4'h0, 32'h0);
        check("oor_r_rvalid", {63'd0, rvalid}, 64'd1);
        check("oor_r_rdata",  {32'd0, rdata},  64'd0);
        check("oor_r_err",    {63'd0, err},    64'd1);
        @(negedge clk);
        xfer(1'b0, 32'h80000010, 4'h0, 32'h0);
        check("hi_bit_err", {63'd0, err}, 64'd1);
        @(negedge clk);
        // Last in-range word
        xfer(1'b1, 32'h3FFC, 4'hF, 32'hCAFEF00D);
        check("top_w_err", {63'd0, err}, 64'd0);
        @(negedge clk);
        xfer(1'b0, 32'h3FFF, 4'h0, 32'h0);
        check("top_r_rdata", {32'd0, rdata}, 64'h0CAFEF00D);
        check("top_r_err",   {63'd0, err},   64'd0);
        @(negedge clk);

        // Back-to-back reads with req held
        req = 1'b1; we = 1'b0; addr = 32'h10;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("b2b_ready_%0d", k),  {63'd0, ready},  (k % 2 == 0) ? 64'd1 : 64'd0);
            check($sformatf("b2b_rvalid_%0d", k), {63'd0, rvalid}, (k % 2 == 1) ? 64'd1 : 64'd0);
            @(negedge clk);
        end
        // Reset in IDLE with req held: no accept, rdata cleared
        rst = 1'b0;
        @(negedge clk);
        check("rst_idle_rvalid", {63'd0, rvalid}, 64'd0);
        check("rst_idle_ready",  {63'd0, ready},  64'd1);
        check("rst_idle_rdata",  {32'd0, rdata},  64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_rvalid", {63'd0, rvalid}, 64'd1);
        check("post_rst_rdata",  {32'd0, rdata},  64'h0DE22BE44);
        // Reset in RESP
        rst = 1'b0; req = 1'b0;
        @(negedge clk);
        check("rst_resp_rvalid", {63'd0, rvalid}, 64'd0);
        check("rst_resp_ready",  {63'd0, ready},  64'd1);
        rst = 1'b1;
        @(negedge clk);

        // Parity
        xfer(1'b1, 32'h20, 4'hF, 32'hA5A5A5A5);
        @(negedge clk);
`ifdef RAM_PARITY_EN
        dut.mem[8] = dut.mem[8] ^ 32'h1;
        xfer(1'b0, 32'h20, 4'h0, 32'h0);
        check("par_rvalid", {63'd0, rvalid}, 64'd1);
        check("par_err",    {63'd0, err},    64'd1);
        check("par_rdata",  {32'd0, rdata},  64'h0A5A5A5A4);
`else
        xfer(1'b0, 32'h20, 4'h0, 32'h0);
        check("par_rvalid", {63'd0, rvalid}, 64'd1);
        check("par_err",    {63'd0, err},    64'd0);
        check("par_rdata",  {32'd0, rdata},  64'h0A5A5A5A5);
`endif
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
